// File: rtl/cursor_ctrl.sv
// Purpose : brush/cursor controller. It synchronises and debounces the buttons,
//           accelerates movement while a direction is held, and clamps the position.
// Latency : a button is seen 2+DB_CYCLES cycles after it changes. Colour and width
//           update one cycle later. Position and moved_out update on the nf_in edge.
// Backpr. : none. Updates are paced by nf_in, there is no stall, and every frame is consumed.
// Ports   : clk_in/rst_n_in are the clock and the async active-low reset.
//           pos_con_in[3:0] is up/down/right/left. col_con_in advances the colour.
//           sw_con_in advances the stroke width. nf_in is the new-frame strobe.
//           cursor_loc_x/y, cursor_color, stroke_width and moved_out are the outputs.
module cursor_ctrl #(
   parameter int X_MAX        = 638,
   parameter int Y_MAX        = 359,
   parameter int X_RESET      = 320,
   parameter int Y_RESET      = 180,
   parameter int X_W          = 10,
   parameter int Y_W          = 9,
   parameter int COLOR_W      = 4,
   parameter int WIDTH_MAX    = 7,
   parameter int WIDTH_W      = 3,
   parameter int STEP_MIN     = 1,
   parameter int STEP_MAX     = 8,
   parameter int ACCEL_FRAMES = 16,
   parameter int DB_CYCLES    = 1000
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic [3:0]         pos_con_in,
   input  logic               col_con_in,
   input  logic               sw_con_in,
   input  logic               nf_in,
   output logic [X_W-1:0]     cursor_loc_x,
   output logic [Y_W-1:0]     cursor_loc_y,
   output logic [COLOR_W-1:0] cursor_color,
   output logic [WIDTH_W-1:0] stroke_width,
   output logic               moved_out
);

   localparam int NB     = 6;
   localparam int DB_W   = $clog2(DB_CYCLES + 1);
   localparam int STEP_W = $clog2(STEP_MAX + 1);
   localparam int CNT_W  = $clog2(ACCEL_FRAMES + 1);

   // ---------------- input conditioning ----------------
   logic [NB-1:0] raw, sync1, sync2, db;

   assign raw = {sw_con_in, col_con_in, pos_con_in};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed from db for DB_CYCLES
   // consecutive cycles. Any bounce back to db restarts the count.
   for (genvar i = 0; i < NB; i++) begin : g_db
      logic            db_q;
      logic [DB_W-1:0] cnt_q;

      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
         end else if (sync2[i] == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_q  <= sync2[i];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DB_W'(1);
         end
      end

      assign db[i] = db_q;
   end

   logic dir_up, dir_down, dir_right, dir_left, any_dir, col_db, sw_db;

   assign dir_up    = db[0];
   assign dir_down  = db[1];
   assign dir_right = db[2];
   assign dir_left  = db[3];
   assign any_dir   = |db[3:0];
   assign col_db    = db[4];
   assign sw_db     = db[5];

   // ---------------- acceleration FSM ----------------
   typedef enum logic [1:0] {S_IDLE, S_RAMP, S_MAX} state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d, step_use;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [STEP_W:0]     step_dbl;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         step_q  <= STEP_W'(STEP_MIN);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
      end
   end

   // IDLE and RAMP share the counting rule. The counter is always clear in IDLE,
   // so the first held frame counts toward the first doubling.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      cnt_inc  = cnt_q + CNT_W'(1);
      step_dbl = {step_q, 1'b0};
      if (nf_in) begin
         if (!any_dir) begin
            state_d = S_IDLE;
            step_d  = STEP_W'(STEP_MIN);
            cnt_d   = '0;
         end else begin
            case (state_q)
               S_IDLE, S_RAMP: begin
                  if (cnt_inc == CNT_W'(ACCEL_FRAMES)) begin
                     cnt_d  = '0;
                     step_d = (step_dbl > (STEP_W+1)'(STEP_MAX)) ? STEP_W'(STEP_MAX)
                                                                  : step_dbl[STEP_W-1:0];
                  end else begin
                     cnt_d = cnt_inc;
                  end
                  state_d = (step_d == STEP_W'(STEP_MAX)) ? S_MAX : S_RAMP;
               end
               default: begin
                  state_d = S_MAX;
                  step_d  = STEP_W'(STEP_MAX);
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   // The move uses the step from before this frame's update.
   always_comb begin
      step_use = (state_q == S_MAX) ? STEP_W'(STEP_MAX) : step_q;
   end

   // ---------------- movement ----------------
   logic [X_W:0]   x_step, x_sum;
   logic [Y_W:0]   y_step, y_sum;
   logic [X_W-1:0] x_d;
   logic [Y_W-1:0] y_d;

   always_comb begin
      x_step = (X_W+1)'(step_use);
      y_step = (Y_W+1)'(step_use);
      x_sum  = {1'b0, cursor_loc_x} + x_step;
      y_sum  = {1'b0, cursor_loc_y} + y_step;
      x_d    = cursor_loc_x;
      y_d    = cursor_loc_y;
      // When both buttons on an axis are held, they cancel and fall to the default.
      case ({dir_left, dir_right})
         2'b01:   x_d = (x_sum > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : x_sum[X_W-1:0];
         2'b10:   x_d = ({1'b0, cursor_loc_x} <= x_step) ? '0
                        : cursor_loc_x - x_step[X_W-1:0];
         default: x_d = cursor_loc_x;
      endcase
      case ({dir_up, dir_down})
         2'b01:   y_d = (y_sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : y_sum[Y_W-1:0];
         2'b10:   y_d = ({1'b0, cursor_loc_y} <= y_step) ? '0
                        : cursor_loc_y - y_step[Y_W-1:0];
         default: y_d = cursor_loc_y;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cursor_loc_x <= X_W'(X_RESET);
         cursor_loc_y <= Y_W'(Y_RESET);
         moved_out    <= 1'b0;
      end else if (nf_in) begin
         cursor_loc_x <= x_d;
         cursor_loc_y <= y_d;
         moved_out    <= (x_d != cursor_loc_x) || (y_d != cursor_loc_y);
      end else begin
         moved_out    <= 1'b0;
      end
   end

   // ---------------- colour / stroke width ----------------
   logic col_prev, sw_prev;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         col_prev     <= 1'b0;
         sw_prev      <= 1'b0;
         cursor_color <= '0;
         stroke_width <= '0;
      end else begin
         col_prev <= col_db;
         sw_prev  <= sw_db;
         if (col_db && !col_prev)
            cursor_color <= cursor_color + COLOR_W'(1);
         if (sw_db && !sw_prev)
            stroke_width <= (stroke_width == WIDTH_W'(WIDTH_MAX)) ? '0
                            : stroke_width + WIDTH_W'(1);
      end
   end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Purpose : self-checking bench for cursor_ctrl with short debounce and acceleration.
// Latency : frames are driven after the buttons have settled, then checked 1ns after the edge.
// Backpr. : none, because the stimulus is fully paced by the bench.
module tb_cursor_ctrl;

   localparam int DB     = 4;
   localparam int AF     = 2;
   localparam int SMAX   = 4;
   localparam int SETTLE = DB + 6;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [3:0] pos_con_in;
   logic       col_con_in, sw_con_in, nf_in;
   logic [9:0] cursor_loc_x;
   logic [8:0] cursor_loc_y;
   logic [3:0] cursor_color;
   logic [2:0] stroke_width;
   logic       moved_out;

   always #5 clk_in = ~clk_in;

   cursor_ctrl #(
      .X_MAX(638), .Y_MAX(359), .X_RESET(320), .Y_RESET(180), .X_W(10), .Y_W(9),
      .COLOR_W(4), .WIDTH_MAX(7), .WIDTH_W(3), .STEP_MIN(1), .STEP_MAX(SMAX),
      .ACCEL_FRAMES(AF), .DB_CYCLES(DB)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .pos_con_in(pos_con_in),
      .col_con_in(col_con_in), .sw_con_in(sw_con_in), .nf_in(nf_in),
      .cursor_loc_x(cursor_loc_x), .cursor_loc_y(cursor_loc_y),
      .cursor_color(cursor_color), .stroke_width(stroke_width), .moved_out(moved_out)
   );

   typedef struct { logic [3:0] dir; int ex; int ey; int em; } vec_t;
   typedef struct { int x; int y; int m; } exp_t;

   vec_t tbl [21];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ex, ey, st, nx, ny;

   task automatic check(input string nm, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"},     cursor_loc_x, 320);
      check({tag, "_y"},     cursor_loc_y, 180);
      check({tag, "_color"}, cursor_color, 0);
      check({tag, "_width"}, stroke_width, 0);
      check({tag, "_moved"}, moved_out,    0);
   endtask

   // Settle the buttons, push the expectation, strobe one frame, then pop and compare.
   task automatic frame(input logic [3:0] dir, input int fx, input int fy, input int fm,
                        input string tag);
      exp_t e, got;
      @(negedge clk_in);
      pos_con_in = dir;
      repeat (SETTLE) @(negedge clk_in);
      e.x = fx; e.y = fy; e.m = fm;
      sb.push_back(e);
      nf_in = 1'b1;
      @(posedge clk_in); #1;
      got = sb.pop_front();
      check({tag, "_x"},     cursor_loc_x, got.x);
      check({tag, "_y"},     cursor_loc_y, got.y);
      check({tag, "_moved"}, moved_out,    got.m);
      @(negedge clk_in);
      nf_in = 1'b0;
      @(posedge clk_in); #1;
      check({tag, "_moved_clear"}, moved_out, 0);
   endtask

   task automatic press(input logic c, input logic s, input int hold);
      @(negedge clk_in);
      col_con_in = c;
      sw_con_in  = s;
      repeat (hold) @(negedge clk_in);
      col_con_in = 1'b0;
      sw_con_in  = 1'b0;
      repeat (SETTLE) @(negedge clk_in);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      // up=0001 down=0010 right=0100 left=1000
      tbl[0]  = '{4'b0100, 321, 180, 1};
      tbl[1]  = '{4'b0000, 321, 180, 0};
      tbl[2]  = '{4'b0100, 322, 180, 1};
      tbl[3]  = '{4'b0100, 323, 180, 1};
      tbl[4]  = '{4'b0100, 325, 180, 1};
      tbl[5]  = '{4'b0100, 327, 180, 1};
      tbl[6]  = '{4'b0100, 331, 180, 1};
      tbl[7]  = '{4'b0100, 335, 180, 1};
      tbl[8]  = '{4'b0000, 335, 180, 0};
      tbl[9]  = '{4'b0100, 336, 180, 1};
      tbl[10] = '{4'b0011, 336, 180, 0};
      tbl[11] = '{4'b0011, 336, 180, 0};
      tbl[12] = '{4'b0011, 336, 180, 0};
      tbl[13] = '{4'b0111, 340, 180, 1};
      tbl[14] = '{4'b1100, 340, 180, 0};
      tbl[15] = '{4'b0010, 340, 184, 1};
      tbl[16] = '{4'b0001, 340, 180, 1};
      tbl[17] = '{4'b1000, 336, 180, 1};
      tbl[18] = '{4'b0000, 336, 180, 0};
      tbl[19] = '{4'b1000, 335, 180, 1};
      tbl[20] = '{4'b0000, 335, 180, 0};

      rst_n_in   = 1'b0;
      pos_con_in = 4'b0000;
      col_con_in = 1'b0;
      sw_con_in  = 1'b0;
      nf_in      = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_vals("rst");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      check_reset_vals("post_rst");

      // basic move, acceleration, release, cancellation
      for (int i = 0; i < 21; i++)
         frame(tbl[i].dir, tbl[i].ex, tbl[i].ey, tbl[i].em, $sformatf("vec%0d", i));

      // right-edge clamp: step schedule 1,1,2,2 then 4
      ex = 335;
      for (int f = 0; f < 82; f++) begin
         st = (f < 2) ? 1 : (f < 4) ? 2 : 4;
         nx = (ex + st > 638) ? 638 : ex + st;
         frame(4'b0100, nx, 180, (nx != ex) ? 1 : 0, $sformatf("xclamp%0d", f));
         if (f == 77) check("x_reaches_637", cursor_loc_x, 637);
         if (f == 78) check("x_clamped_638", cursor_loc_x, 638);
         ex = nx;
      end
      frame(4'b0000, 638, 180, 0, "xrel");

      // top-edge clamp: y steps 180 -> 174 -> ... -> 2 -> 0
      ey = 180;
      for (int f = 0; f < 50; f++) begin
         st = (f < 2) ? 1 : (f < 4) ? 2 : 4;
         ny = (ey <= st) ? 0 : ey - st;
         frame(4'b0001, 638, ny, (ny != ey) ? 1 : 0, $sformatf("yclamp%0d", f));
         if (f == 46) check("y_reaches_2", cursor_loc_y, 2);
         if (f == 47) check("y_clamped_0", cursor_loc_y, 0);
         ey = ny;
      end
      frame(4'b0000, 638, 0, 0, "yrel");

      // colour and width wrap
      for (int i = 0; i < 16; i++) begin
         press(1'b1, 1'b0, SETTLE);
         check($sformatf("color_press%0d", i), cursor_color, (i + 1) % 16);
      end
      for (int i = 0; i < 8; i++) begin
         press(1'b0, 1'b1, SETTLE);
         check($sformatf("width_press%0d", i), stroke_width, (i + 1) % 8);
      end
      press(1'b1, 1'b1, DB - 1);
      check("bounce_color", cursor_color, 0);
      check("bounce_width", stroke_width, 0);
      press(1'b1, 1'b0, DB);
      check("min_pulse_color", cursor_color, 1);
      press(1'b1, 1'b1, SETTLE);
      check("both_color", cursor_color, 2);
      check("both_width", stroke_width, 1);

      // reset during RAMP (step 2) and mid-debounce of colour
      frame(4'b1000, 637, 0, 1, "pre_rst0");
      frame(4'b1000, 636, 0, 1, "pre_rst1");
      @(negedge clk_in);
      col_con_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      check_reset_vals("async_rst");
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_vals("held_rst");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (2 + DB) @(posedge clk_in);
      #1;
      check("color_before_full_debounce", cursor_color, 0);
      @(posedge clk_in); #1;
      check("color_after_full_debounce", cursor_color, 1);
      @(negedge clk_in);
      col_con_in = 1'b0;
      frame(4'b1000, 319, 180, 1, "post_rst0");
      frame(4'b1000, 318, 180, 1, "post_rst1");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Parametrised cursor/brush controller for the drawing pipeline. Takes raw direction, colour and stroke-width buttons and a once-per-frame strobe, and produces a clamped cursor position, colour index and stroke width for the draw and render stages. Direction inputs accelerate while held. Opposing directions cancel. All buttons are synchronised and debounced internally.

## Interface
- `X_MAX`, 638: largest legal cursor x.
- `Y_MAX`, 359: largest legal cursor y.
- `X_RESET`, 320 / `Y_RESET`, 180: position after reset.
- `X_W`, 10 / `Y_W`, 9: position widths. Must satisfy X_MAX < 2^X_W and Y_MAX < 2^Y_W.
- `COLOR_W`, 4: colour index width.
- `WIDTH_MAX`, 7: largest stroke width. `WIDTH_W`, 3: its width.
- `STEP_MIN`, 1 / `STEP_MAX`, 8: per-frame move amount, initial and saturated.
- `ACCEL_FRAMES`, 16: consecutive held frames per acceleration step.
- `DB_CYCLES`, 1000: cycles a button must be stable before it is accepted. Must be ≥ 1.

Ports:
- `clk_in`, in, 1: system clock.
- `rst_n_in`, in, 1: asynchronous, active-low reset.
- `pos_con_in`, in, 4: raw direction buttons. Bit 0 is up, 1 down, 2 right, 3 left.
- `col_con_in`, in, 1: raw colour-advance button.
- `sw_con_in`, in, 1: raw stroke-width-advance button.
- `nf_in`, in, 1: new-frame strobe, one cycle high, already synchronous to `clk_in`.
- `cursor_loc_x`, out, X_W: cursor x.
- `cursor_loc_y`, out, Y_W: cursor y.
- `cursor_color`, out, COLOR_W: colour index.
- `stroke_width`, out, WIDTH_W: stroke width.
- `moved_out`, out, 1: one-cycle pulse when the position changed.

## Operation
- **Input conditioning**
  - Each of the 6 raw buttons passes through a 2-flop synchroniser and then its own debounce counter.
  - The debounced value `db` changes only after the synchronised value has differed from `db` for DB_CYCLES consecutive cycles.
  - Any bounce restarts that counter at 0.
- **Direction resolution**, per axis, from debounced bits:
  - up and down both held: no y move.
  - right and left both held: no x move.
- **Acceleration FSM**, advanced only on cycles with `nf_in` = 1.
  - IDLE: step = STEP_MIN. Goes to RAMP when any direction bit is held.
  - RAMP: a frame counter counts held frames.
    - When the counter reaches ACCEL_FRAMES: step ← min(step×2, STEP_MAX) and the counter clears.
    - When step equals STEP_MAX, go to MAX.
  - MAX: step stays at STEP_MAX.
  - From RAMP or MAX: all direction bits released at an `nf_in` cycle → IDLE, step = STEP_MIN, counter = 0.
  - A cancelled axis still counts as held for acceleration.
  - Movement in a frame uses the step value held before that frame's FSM update.
- **Movement**, on `nf_in`:
  - Decrement: result is 0 if the current value ≤ step, else value − step.
  - Increment: result is the MAX parameter if value + step > MAX, else value + step.
  - Compute sums at X_W+1 / Y_W+1 bits so the add cannot wrap.
  - Both axes update in the same cycle.
- **`moved_out`**: 1 for one cycle when the new x or y differs from the old one. It stays 0 when a move is clamped at the boundary with no change.
- **Colour**: on each rising edge of debounced colour, `cursor_color` ← `cursor_color` + 1 modulo 2^COLOR_W, so all-ones wraps to 0.
- **Stroke width**: on each rising edge of debounced stroke width, `stroke_width` ← 0 if it equals WIDTH_MAX, else `stroke_width` + 1.
- Colour and width edges act independently of `nf_in` and of movement. They may occur in the same cycle.

## Timing
- **Reset values**:
  - `cursor_loc_x` = X_RESET, `cursor_loc_y` = Y_RESET.
  - `cursor_color` = 0, `stroke_width` = 0, `moved_out` = 0.
  - All synchronisers, debounce counters and previous-value flops = 0.
  - FSM = IDLE, step = STEP_MIN, frame counter = 0.
- Reset assertion takes effect immediately, including mid-debounce or mid-ramp. Deassertion is used synchronously; first state update is at the first clock edge after release.
- **Button latency**, raw change to `db` change: 2 synchroniser cycles + DB_CYCLES.
- Colour and width outputs update on the edge after the `db` rising edge.
- Position and `moved_out` register on the clock edge that samples `nf_in` = 1.
- Back-to-back `nf_in` on consecutive cycles is legal; each one is a frame.

## Test plan
1. **Reset and basic move.** Params: DB_CYCLES=4, ACCEL_FRAMES=2, STEP_MAX=4. Release reset, hold right through 1 frame after debounce → x 320→321, `moved_out` pulses once.
2. **Acceleration and release.** Same params. Hold right for 6 frames → per-frame x steps 1,1,2,2,4,4, FSM in MAX. Release for 1 frame, then hold again → step back to 1.
3. **Clamping.** Start x=637, step 4, moving right → x=638, then stays 638 with `moved_out`=0. Start y=2, step 4, moving up → y=0.
4. **Opposing directions.** Up and down held together for 3 frames → y unchanged, `moved_out`=0, step still accelerates.
5. **Wrap-around.** 16 colour presses → colour 1..15 then 0. 8 width presses → width 1..7 then 0. A bounce pulse shorter than DB_CYCLES → no change.
6. **Reset mid-operation.** Assert `rst_n_in` low during RAMP and mid-debounce → outputs return to reset values immediately. After release, a partly debounced press registers only after a full 2+DB_CYCLES.
